people_counter: RTL and testbench
=================================

// Module: people_counter
// PURPOSE
//  Upstream stage of the queue wait-time lookup. Turns two raw photo-sensor lines (queue entry, queue exit)
//  into a saturating head-count pCount[2:0] that drives the wait-time LUT index.
//  Synchronises and debounces both sensors, detects person events, flags full/empty and rejected events.
//  All outputs are registered on posedge clk, so they are stable for the LUT's negedge sample.
// PARAMETERS
//  DEB_CYCLES  4  consecutive synchronised cycles a sensor must hold a new level before it is accepted (>=1)
//  MAX_COUNT   7  saturation ceiling for pCount (1..7; pCount is 3 bits)
// PORTS
//  clk             in   1  system clock, all logic on posedge
//  reset           in   1  synchronous, active-high reset
//  sensor_in       in   1  raw entry beam, 1 = beam blocked; asynchronous to clk
//  sensor_out      in   1  raw exit beam, 1 = beam blocked; asynchronous to clk
//  pCount          out  3  people currently in queue, 0..MAX_COUNT
//  full            out  1  pCount == MAX_COUNT
//  empty           out  1  pCount == 0
//  count_changed   out  1  1-cycle pulse on the cycle pCount takes a new value
//  entry_rejected  out  1  1-cycle pulse: entry event arrived while full (count held)
//  exit_rejected   out  1  1-cycle pulse: exit event arrived while empty (count held)
// BEHAVIOUR
//  Reset (reset=1 at posedge): pCount=0, empty=1, full=0, all pulses 0; sync FFs, debounced levels and
//   debounce counters = 0. Reset mid-debounce or mid-event discards the pending event.
//  Per sensor, identical channels:
//   - 2-FF synchroniser -> s.
//   - Debouncer: deb level + counter. s==deb -> counter cleared. s!=deb -> counter++; when counter reaches
//     DEB_CYCLES-1 with s still !=deb, deb<=s and counter cleared. Any glitch back to deb restarts the count.
//   - Event = registered rising edge of deb (0->1). Falling edges generate nothing.
//  Latency: raw sensor first sampled high at posedge N (and held) -> pCount/pulses update at posedge
//   N+DEB_CYCLES+3. Fixed and equal on both channels.
//  Count update on the cycle events are presented:
//   - entry only: pCount<MAX_COUNT -> +1, count_changed=1; else hold, entry_rejected=1.
//   - exit only : pCount>0 -> -1, count_changed=1; else hold, exit_rejected=1.
//   - entry and exit same cycle: pCount held, no pulses (net zero, including at full or empty).
//   - no event: hold, all pulses 0.
//  full/empty are registered alongside pCount and always consistent with it in the same cycle.
//  pCount never wraps: no 7->0 or 0->7 transition is legal.
//  A sensor held blocked indefinitely produces exactly one event; the next needs deb to return to 0 first.
// TESTING (DEB_CYCLES=4, MAX_COUNT=7)
//  1 reset: assert reset 2 cycles with sensors toggling -> pCount=0, empty=1, full=0, no pulses.
//  2 single entry: sensor_in high from posedge 10 for 8 cycles -> pCount 0->1 at posedge 17,
//    count_changed pulse 1 cycle, empty drops the same cycle.
//  3 glitch reject: sensor_in high 3 cycles then low -> pCount unchanged, no pulses.
//    Repeat with a 1-cycle low dip inside a 6-cycle high -> no event.
//  4 saturation: 9 clean entries -> pCount reaches 7 after the 7th, full=1;
//    8th and 9th give entry_rejected pulses, pCount stays 7.
//  5 underflow: from empty, 2 exit events -> 2 exit_rejected pulses, pCount=0, empty stays 1.
//  6 simultaneous: pCount=3, identical entry+exit waveforms -> pCount stays 3, no pulses.
//    Repeat at pCount=7 and pCount=0 -> same.
//    Reset asserted 2 cycles into a debounce -> no event after reset is released.

Source files
------------

// File: rtl/people_counter.sv
// people_counter: turns two raw, asynchronous photo-sensor lines (queue entry and exit) into a
// saturating 3-bit head count with full/empty flags and single-cycle change/reject pulses.
// Each sensor channel runs through a 2-FF synchroniser, a level debouncer and a registered
// rising-edge detector. The two channels are identical, so the entry-to-count latency matches
// the exit-to-count latency. Every output is registered on posedge clk.
module people_counter #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned MAX_COUNT  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_in,
  input  logic       sensor_out,
  output logic [2:0] pCount,
  output logic       full,
  output logic       empty,
  output logic       count_changed,
  output logic       entry_rejected,
  output logic       exit_rejected
);

  // The debounce counter only has to reach DEB_CYCLES-1; keep at least one bit.
  localparam int unsigned     CntW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [2:0]      MaxCnt  = 3'(MAX_COUNT);

  // Channel 0 is the entry beam, channel 1 is the exit beam.
  logic [1:0] w_raw;
  logic [1:0] w_evt;

  assign w_raw = {sensor_out, sensor_in};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic            r_meta;
    logic            r_sync;
    logic            r_deb;
    logic            r_deb_q;
    logic            r_evt;
    logic [CntW-1:0] r_cnt;
    logic            w_deb_d;
    logic [CntW-1:0] w_cnt_d;

    // Debounce next state: a new level must persist DEB_CYCLES samples; any sample equal to the
    // accepted level throws the partial count away.
    always_comb begin
      w_deb_d = r_deb;
      w_cnt_d = '0;
      if (r_sync != r_deb) begin
        if (r_cnt == CntLast) begin
          w_deb_d = r_sync;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
    end

    // Synchroniser, debounced level and registered 0->1 edge of that level.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
        r_evt   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_meta  <= w_raw[g];
        r_sync  <= r_meta;
        r_deb   <= w_deb_d;
        r_deb_q <= r_deb;
        r_evt   <= r_deb & ~r_deb_q;
        r_cnt   <= w_cnt_d;
      end
    end

    assign w_evt[g] = r_evt;
  end

  logic [2:0] r_count;
  logic       r_full;
  logic       r_empty;
  logic       r_changed;
  logic       r_entry_rej;
  logic       r_exit_rej;

  logic [2:0] w_count_d;
  logic       w_changed_d;
  logic       w_entry_rej_d;
  logic       w_exit_rej_d;

  // Count update: saturate at both ends; coincident entry and exit cancel with no pulses.
  always_comb begin
    w_count_d     = r_count;
    w_changed_d   = 1'b0;
    w_entry_rej_d = 1'b0;
    w_exit_rej_d  = 1'b0;
    unique case (w_evt)
      2'b01: begin
        if (r_count < MaxCnt) begin
          w_count_d   = r_count + 3'd1;
          w_changed_d = 1'b1;
        end else begin
          w_entry_rej_d = 1'b1;
        end
      end
      2'b10: begin
        if (r_count != 3'd0) begin
          w_count_d   = r_count - 3'd1;
          w_changed_d = 1'b1;
        end else begin
          w_exit_rej_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Flags are derived from the next count so they always agree with pCount in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 3'd0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_changed   <= 1'b0;
      r_entry_rej <= 1'b0;
      r_exit_rej  <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_full      <= (w_count_d == MaxCnt);
      r_empty     <= (w_count_d == 3'd0);
      r_changed   <= w_changed_d;
      r_entry_rej <= w_entry_rej_d;
      r_exit_rej  <= w_exit_rej_d;
    end
  end

  assign pCount         = r_count;
  assign full           = r_full;
  assign empty          = r_empty;
  assign count_changed  = r_changed;
  assign entry_rejected = r_entry_rej;
  assign exit_rejected  = r_exit_rej;

endmodule

// File: tb/tb_people_counter.sv
// Bench for people_counter (DEB_CYCLES=4, MAX_COUNT=7): a vector table of sensor waveforms with
// expected end state and pulse totals, a scoreboard of timed expectations checked at negedge,
// and hand sequences for reset, exact latency and reset during a debounce.
module tb_people_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_in;
  logic       sensor_out;
  logic [2:0] pCount;
  logic       full;
  logic       empty;
  logic       count_changed;
  logic       entry_rejected;
  logic       exit_rejected;

  people_counter #(
    .DEB_CYCLES(4),
    .MAX_COUNT (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_in     (sensor_in),
    .sensor_out    (sensor_out),
    .pCount        (pCount),
    .full          (full),
    .empty         (empty),
    .count_changed (count_changed),
    .entry_rejected(entry_rejected),
    .exit_rejected (exit_rejected)
  );

  always #5 clk = ~clk;

  // Number of posedges seen so far; stable when read at negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int t_chg   = 0;
  int t_erej  = 0;
  int t_xrej  = 0;

  logic [23:0] obs;
  assign obs = 24'({pCount, full, empty, count_changed, entry_rejected, exit_rejected});

  typedef struct {
    int          at;
    logic [23:0] exp;
    int          id;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit [15:0] in_pat;
    bit [15:0] out_pat;
    int        upd_at;  // pattern index whose sample starts the accepted run, -1 = no event
    bit [2:0]  cnt;
    bit        chg;
    bit        erej;
    bit        xrej;
  } vec_t;
  vec_t vecs[20];

  function automatic logic [23:0] exp_out(input bit [2:0] c, input bit chg, input bit er,
                                          input bit xr);
    return 24'({c, c == 3'd7, c == 3'd0, chg, er, xr});
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: tallies pulses and retires scoreboard entries that fall due this cycle.
  always @(negedge clk) begin : mon
    sb_t e;
    t_chg  += int'(count_changed);
    t_erej += int'(entry_rejected);
    t_xrej += int'(exit_rejected);
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check($sformatf("update_v%0d", e.id), obs, e.exp);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive a vector for 16 cycles plus 12 idle cycles, then check the end state and pulse totals.
  task automatic apply(input int id);
    vec_t v;
    int   c0, s_chg, s_erej, s_xrej;
    v = vecs[id];
    @(negedge clk);
    #1;
    s_chg  = t_chg;
    s_erej = t_erej;
    s_xrej = t_xrej;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      sensor_in  = (i < 16) ? v.in_pat[i] : 1'b0;
      sensor_out = (i < 16) ? v.out_pat[i] : 1'b0;
      // Sampled at posedge c0+i+1; result visible DEB_CYCLES+3 posedges later.
      if (i == v.upd_at) sb.push_back('{c0 + i + 8, exp_out(v.cnt, v.chg, v.erej, v.xrej), id});
    end
    @(negedge clk);
    #1;
    check($sformatf("end_state_v%0d", id), obs, exp_out(v.cnt, 1'b0, 1'b0, 1'b0));
    check($sformatf("pulse_tally_v%0d", id),
          {8'(t_chg - s_chg), 8'(t_erej - s_erej), 8'(t_xrej - s_xrej)},
          {8'(v.chg), 8'(v.erej), 8'(v.xrej)});
  endtask

  initial begin
    int c0, s_chg, s_erej, s_xrej;

    vecs[0]  = '{16'h0007, 16'h0000, -1, 3'd0, 1'b0, 1'b0, 1'b0};  // 3-cycle glitch
    vecs[1]  = '{16'h0037, 16'h0000, -1, 3'd0, 1'b0, 1'b0, 1'b0};  // 6 high with 1-cycle dip
    vecs[2]  = '{16'h0000, 16'h00FF,  0, 3'd0, 1'b0, 1'b0, 1'b1};  // exit while empty
    vecs[3]  = '{16'h0000, 16'h00FF,  0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h00FF, 16'h00FF, -1, 3'd0, 1'b0, 1'b0, 1'b0};  // simultaneous at 0
    vecs[5]  = '{16'h00FF, 16'h0000,  0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h00FF, 16'h0000,  0, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h00FF, 16'h0000,  0, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'h00FF, 16'h00FF, -1, 3'd3, 1'b0, 1'b0, 1'b0};  // simultaneous at 3
    vecs[9]  = '{16'h0000, 16'h00FF,  0, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h0FF0, 16'h0000,  4, 3'd3, 1'b1, 1'b0, 1'b0};  // late-starting entry
    vecs[11] = '{16'h00FF, 16'h0000,  0, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'h00FF, 16'h0000,  0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{16'h00FF, 16'h0000,  0, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{16'h00FF, 16'h0000,  0, 3'd7, 1'b1, 1'b0, 1'b0};  // reaches full
    vecs[15] = '{16'h00FF, 16'h0000,  0, 3'd7, 1'b0, 1'b1, 1'b0};  // entry while full
    vecs[16] = '{16'h00FF, 16'h0000,  0, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{16'h00FF, 16'h00FF, -1, 3'd7, 1'b0, 1'b0, 1'b0};  // simultaneous at 7
    vecs[18] = '{16'h0000, 16'h0FF0,  4, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{16'hFFFF, 16'h0000,  0, 3'd7, 1'b1, 1'b0, 1'b0};  // held blocked: one event

    // Reset held two cycles while both sensors toggle.
    reset      = 1'b1;
    sensor_in  = 1'b0;
    sensor_out = 1'b1;
    repeat (2) begin
      @(negedge clk);
      sensor_in  = ~sensor_in;
      sensor_out = ~sensor_out;
    end
    check("reset_state", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));
    reset      = 1'b0;
    sensor_in  = 1'b0;
    sensor_out = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));

    // Single entry, 8 cycles high: count moves exactly DEB_CYCLES+3 posedges after first sample.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      sensor_in = (i < 8);
      if (cyc == c0 + 7) check("entry_before_latency", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));
      if (cyc == c0 + 8) check("entry_at_latency", obs, exp_out(3'd1, 1'b1, 1'b0, 1'b0));
      if (cyc == c0 + 9) check("entry_pulse_ends", obs, exp_out(3'd1, 1'b0, 1'b0, 1'b0));
    end
    sensor_in = 1'b0;

    do_reset();
    repeat (2) @(negedge clk);
    check("reset_from_one", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));

    for (int k = 0; k < 20; k++) apply(k);

    // Reset two cycles into a debounce; the pending entry must be discarded.
    @(negedge clk);
    sensor_in = 1'b1;
    repeat (4) @(negedge clk);
    reset     = 1'b1;
    sensor_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    s_chg  = t_chg;
    s_erej = t_erej;
    s_xrej = t_xrej;
    check("reset_mid_debounce", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));
    repeat (15) @(negedge clk);
    #1;
    check("no_event_after_reset", obs, exp_out(3'd0, 1'b0, 1'b0, 1'b0));
    check("no_pulse_after_reset", {8'(t_chg - s_chg), 8'(t_erej - s_erej), 8'(t_xrej - s_xrej)},
          24'd0);

    check("scoreboard_drained", 24'(sb.size()), 24'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
